// File: rtl/spi_regif_pkg.sv
// Shared definitions for the SPI register-interface slave: opcodes, status bit
// positions and the frame FSM state encoding.
package spi_regif_pkg;

  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;

  localparam int STAT_BADOP = 0;
  localparam int STAT_TMO   = 1;
  localparam int STAT_ABORT = 2;
  localparam int STAT_ALIGN = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_STAT,
    ST_WAIT_END
  } spi_state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizes sck/ss_n/mosi into clk and derives single-cycle edge pulses.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sck_i,
  input  logic ss_n_i,
  input  logic mosi_i,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic ss_fall_o,
  output logic ss_rise_o,
  output logic mosi_o
);

  // Each stage holds {sck, ss_n, mosi}; stage SYNC_STAGES-1 is the synced value.
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic                        sck_prev_q;
  logic                        ss_prev_q;
  logic                        sck_s;
  logic                        ss_s;

  // ss_n resets to "selected" so a frame already running when reset drops
  // produces no select edge and is never joined halfway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      sck_prev_q <= 1'b0;
      ss_prev_q  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], {sck_i, ss_n_i, mosi_i}};
      sck_prev_q <= sck_s;
      ss_prev_q  <= ss_s;
    end
  end

  assign sck_s      = sync_q[SYNC_STAGES-1][2];
  assign ss_s       = sync_q[SYNC_STAGES-1][1];
  assign mosi_o     = sync_q[SYNC_STAGES-1][0];
  assign sck_rise_o = sck_s & ~sck_prev_q;
  assign sck_fall_o = ~sck_s & sck_prev_q;
  assign ss_fall_o  = ~ss_s & ss_prev_q;
  assign ss_rise_o  = ss_s & ~ss_prev_q;

endmodule

// File: rtl/spi_slave_regif.sv
// SPI mode-0 slave decoding OP/ADDR/DATA frames into register-bus accesses.
// Define SPI_STAT_BYTE_EN to append the 8-bit status byte to every frame.
module spi_slave_regif
  import spi_regif_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sck,
  input  logic              spi_ss_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              reg_ack,
  output logic [7:0]        frame_stat
);

  localparam int CNT_W = $clog2((ADDR_W > DATA_W ? ADDR_W : DATA_W) + 1);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  logic sck_rise, sck_fall, ss_fall, ss_rise, mosi_s;

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .sck_i     (spi_sck),
    .ss_n_i    (spi_ss_n),
    .mosi_i    (spi_mosi),
    .sck_rise_o(sck_rise),
    .sck_fall_o(sck_fall),
    .ss_fall_o (ss_fall),
    .ss_rise_o (ss_rise),
    .mosi_o    (mosi_s)
  );

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic              miso_q, miso_d;
  logic [7:0]        stat_q, stat_d;
  logic              abort_q, abort_d;
  logic              rd_pend_q, rd_pend_d;
  logic              end_pend_q, end_pend_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [DATA_W-1:0] rwdata_q, rwdata_d;
  logic [7:0]        fstat_q, fstat_d;

  logic [7:0]        op_shift;
  logic [ADDR_W-1:0] addr_shift;
  logic [DATA_W-1:0] rx_shift;

  assign op_shift   = {op_q[6:0], mosi_s};
  assign addr_shift = {addr_q[ADDR_W-2:0], mosi_s};
  assign rx_shift   = {rx_q[DATA_W-2:0], mosi_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      addr_q     <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      miso_q     <= 1'b0;
      stat_q     <= '0;
      abort_q    <= 1'b0;
      rd_pend_q  <= 1'b0;
      end_pend_q <= 1'b0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      raddr_q    <= '0;
      rwdata_q   <= '0;
      fstat_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      miso_q     <= miso_d;
      stat_q     <= stat_d;
      abort_q    <= abort_d;
      rd_pend_q  <= rd_pend_d;
      end_pend_q <= end_pend_d;
      we_q       <= we_d;
      re_q       <= re_d;
      raddr_q    <= raddr_d;
      rwdata_q   <= rwdata_d;
      fstat_q    <= fstat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    miso_d     = miso_q;
    stat_d     = stat_q;
    abort_d    = abort_q;
    rd_pend_d  = rd_pend_q;
    end_pend_d = end_pend_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    raddr_d    = raddr_q;
    rwdata_d   = rwdata_q;
    fstat_d    = fstat_q;

    // An outstanding read completes here; the DATA-MSB launch below overrides it.
    if (rd_pend_q && reg_ack) begin
      tx_d      = reg_rdata;
      rd_pend_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          state_d             = ST_CMD;
          cnt_d               = '0;
          op_d                = '0;
          addr_d              = '0;
          rx_d                = '0;
          tx_d                = '0;
          miso_d              = 1'b0;
          stat_d              = '0;
          stat_d[STAT_ABORT]  = abort_q;
          rd_pend_d           = 1'b0;
          end_pend_d          = 1'b0;
        end
      end

      ST_CMD: begin
        if (sck_rise) begin
          op_d = op_shift;
          if (cnt_q == CMD_LAST) begin
            cnt_d              = '0;
            state_d            = ST_ADDR;
            stat_d[STAT_BADOP] = (op_shift != OP_WRITE) && (op_shift != OP_READ);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_ADDR: begin
        if (sck_rise) begin
          addr_d = addr_shift;
          if (cnt_q == ADDR_LAST) begin
            cnt_d              = '0;
            state_d            = ST_DATA;
            stat_d[STAT_ALIGN] = |addr_shift[1:0];
            if (op_q == OP_READ && addr_shift[1:0] == 2'b00) begin
              re_d      = 1'b1;
              raddr_d   = addr_shift;
              rd_pend_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_DATA: begin
        if (sck_fall) begin
          if (cnt_q == '0 && rd_pend_q) begin
            // Read data missed the MSB launch: report timeout and send zeros.
            stat_d[STAT_TMO] = 1'b1;
            rd_pend_d        = 1'b0;
            tx_d             = '0;
            miso_d           = 1'b0;
          end else begin
            miso_d = tx_q[DATA_W-1];
            tx_d   = tx_q << 1;
          end
        end
        if (sck_rise) begin
          rx_d = rx_shift;
          if (cnt_q == DATA_LAST) begin
            cnt_d = '0;
            if (op_q == OP_WRITE && !stat_q[STAT_ALIGN]) begin
              we_d     = 1'b1;
              raddr_d  = addr_q;
              rwdata_d = rx_shift;
            end
`ifdef SPI_STAT_BYTE_EN
            state_d = ST_STAT;
`else
            state_d    = ST_WAIT_END;
            end_pend_d = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_STAT: begin
        if (sck_fall) begin
          if (cnt_q == '0) begin
            miso_d                = stat_q[7];
            tx_d                  = '0;
            tx_d[DATA_W-1 -: 7]   = stat_q[6:0];
          end else begin
            miso_d = tx_q[DATA_W-1];
            tx_d   = tx_q << 1;
          end
        end
        if (sck_rise) begin
          if (cnt_q == CMD_LAST) begin
            cnt_d      = '0;
            state_d    = ST_WAIT_END;
            end_pend_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_WAIT_END: begin
        if (sck_fall || ss_rise) begin
          miso_d = 1'b0;
          if (end_pend_q) begin
            fstat_d    = stat_q;
            abort_d    = 1'b0;
            end_pend_d = 1'b0;
          end
        end
        if (ss_rise) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Deselect before the frame completed: drop it and flag the next frame.
    if (ss_rise && state_q != ST_IDLE && state_q != ST_WAIT_END) begin
      state_d             = ST_IDLE;
      cnt_d               = '0;
      miso_d              = 1'b0;
      we_d                = 1'b0;
      rd_pend_d           = 1'b0;
      end_pend_d          = 1'b0;
      abort_d             = 1'b1;
      fstat_d             = stat_q;
      fstat_d[STAT_ABORT] = 1'b1;
    end
  end

  assign spi_miso   = miso_q;
  assign reg_addr   = raddr_q;
  assign reg_wdata  = rwdata_q;
  assign reg_we     = we_q;
  assign reg_re     = re_q;
  assign frame_stat = fstat_q;

endmodule

// File: tb/tb_spi_slave_regif.sv
// Directed bench for spi_slave_regif: bit-banged SPI master, register-bus
// responder and a queue of expected bus strobes. Follows SPI_STAT_BYTE_EN.
module tb_spi_slave_regif;

`ifdef SPI_STAT_BYTE_EN
  localparam int FRAME_BITS = 64;
`else
  localparam int FRAME_BITS = 56;
`endif
  localparam int HALF = 6;
  localparam int NONE = 1000;

  logic        clk;
  logic        rst;
  logic        spi_sck;
  logic        spi_ss_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic [15:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [31:0] reg_rdata;
  logic        reg_ack;
  logic [7:0]  frame_stat;

  spi_slave_regif dut (
    .clk       (clk),
    .rst       (rst),
    .spi_sck   (spi_sck),
    .spi_ss_n  (spi_ss_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .reg_ack   (reg_ack),
    .frame_stat(frame_stat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [31:0] data;
  } bus_t;

  bus_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] ack_data_v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_monitor();
    bus_t e;
    forever begin
      @(negedge clk);
      if (reg_we === 1'b1 || reg_re === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {30'd0, reg_we, reg_re}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind", {30'd0, reg_we, reg_re}, {30'd0, e.we, ~e.we});
          check("reg_addr", {16'd0, reg_addr}, {16'd0, e.addr});
          if (e.we) check("reg_wdata", reg_wdata, e.data);
        end
      end
    end
  endtask

  task automatic responder();
    int n = 0;
    while (reg_re !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (reg_re === 1'b1) begin
      repeat (2) @(negedge clk);
      reg_rdata = ack_data_v;
      reg_ack   = 1'b1;
      @(negedge clk);
      reg_ack   = 1'b0;
      reg_rdata = '0;
    end
  endtask

  task automatic spi_frame(input logic [7:0] op, input logic [15:0] addr,
                           input logic [31:0] data, input int stop_at,
                           input int rst_at, output logic [63:0] rx);
    logic [63:0] tx;
    tx = {op, addr, data, 8'h00};
    rx = '0;
    spi_ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < FRAME_BITS; i++) begin
      if (i == stop_at) break;
      if (i == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        check("rst.miso", {31'd0, spi_miso}, 32'd0);
        check("rst.we_re", {30'd0, reg_we, reg_re}, 32'd0);
        check("rst.reg_addr", {16'd0, reg_addr}, 32'd0);
        check("rst.reg_wdata", reg_wdata, 32'd0);
        check("rst.frame_stat", {24'd0, frame_stat}, 32'd0);
        rst = 1'b0;
        break;
      end
      spi_mosi = tx[63-i];
      repeat (HALF) @(negedge clk);
      rx[63-i] = spi_miso;
      spi_sck  = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sck  = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    spi_ss_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic do_frame(input string tag, input logic [7:0] op, input logic [15:0] addr,
                          input logic [31:0] data, input int stop_at, input int rst_at,
                          input bit give_ack, input logic [31:0] ack_data,
                          input bit exp_we, input bit exp_re,
                          input logic [31:0] exp_miso, input logic [7:0] exp_stat);
    logic [63:0] rx;
    bus_t        e;
    if (exp_we) begin
      e = '{we: 1'b1, addr: addr, data: data};
      exp_q.push_back(e);
    end
    if (exp_re) begin
      e = '{we: 1'b0, addr: addr, data: 32'd0};
      exp_q.push_back(e);
    end
    if (give_ack) begin
      ack_data_v = ack_data;
      fork
        responder();
      join_none
    end
    spi_frame(op, addr, data, stop_at, rst_at, rx);
    if (stop_at >= FRAME_BITS && rst_at >= FRAME_BITS) begin
      check({tag, ".hdr_miso"}, {8'd0, rx[63:40]}, 32'd0);
      check({tag, ".data_miso"}, rx[39:8], exp_miso);
`ifdef SPI_STAT_BYTE_EN
      check({tag, ".stat_miso"}, {24'd0, rx[7:0]}, {24'd0, exp_stat});
`endif
    end
    check({tag, ".frame_stat"}, {24'd0, frame_stat}, {24'd0, exp_stat});
    check({tag, ".bus_pending"}, exp_q.size(), 32'd0);
    exp_q.delete();
    $display("frame %s op=%h addr=%h miso_data=%h miso_stat=%h frame_stat=%h",
             tag, op, addr, rx[39:8], rx[7:0], frame_stat);
  endtask

  initial begin
    rst        = 1'b1;
    spi_sck    = 1'b0;
    spi_ss_n   = 1'b1;
    spi_mosi   = 1'b0;
    reg_rdata  = '0;
    reg_ack    = 1'b0;
    ack_data_v = '0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    fork
      bus_monitor();
    join_none

    check("reset.miso", {31'd0, spi_miso}, 32'd0);
    check("reset.we_re", {30'd0, reg_we, reg_re}, 32'd0);
    check("reset.reg_addr", {16'd0, reg_addr}, 32'd0);
    check("reset.reg_wdata", reg_wdata, 32'd0);
    check("reset.frame_stat", {24'd0, frame_stat}, 32'd0);

    do_frame("t1_write", 8'h02, 16'h0004, 32'h12345678, NONE, NONE, 0, '0, 1, 0, 32'h0, 8'h00);
    do_frame("t2_read", 8'h03, 16'h0010, 32'h0, NONE, NONE, 1, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 8'h00);
    do_frame("t3_badop", 8'h55, 16'h0008, 32'hAAAAAAAA, NONE, NONE, 0, '0, 0, 0, 32'h0, 8'h01);
    do_frame("t4_abort", 8'h02, 16'h0020, 32'hCAFEF00D, 20, NONE, 0, '0, 0, 0, 32'h0, 8'h04);
    do_frame("t4_read_a", 8'h03, 16'h0014, 32'h0, NONE, NONE, 1, 32'h0BADF00D, 0, 1, 32'h0BADF00D, 8'h04);
    do_frame("t4_read_b", 8'h03, 16'h0018, 32'h0, NONE, NONE, 1, 32'h11223344, 0, 1, 32'h11223344, 8'h00);
    do_frame("t5_noack", 8'h03, 16'h001C, 32'h0, NONE, NONE, 0, '0, 0, 1, 32'h0, 8'h02);

    @(negedge clk);
    reg_rdata = 32'hFFFFFFFF;
    reg_ack   = 1'b1;
    @(negedge clk);
    reg_ack   = 1'b0;
    reg_rdata = '0;
    repeat (4) @(negedge clk);
    check("t5_late_ack.frame_stat", {24'd0, frame_stat}, 32'h02);

    do_frame("t5_after", 8'h03, 16'h0024, 32'h0, NONE, NONE, 1, 32'h55AA55AA, 0, 1, 32'h55AA55AA, 8'h00);
    do_frame("t6_misalign", 8'h02, 16'h0006, 32'h00000009, NONE, NONE, 0, '0, 0, 0, 32'h0, 8'h08);
    do_frame("t6_rst", 8'h02, 16'h0040, 32'h77777777, NONE, 12, 0, '0, 0, 0, 32'h0, 8'h00);
    check("t6_rst.reg_addr_after", {16'd0, reg_addr}, 32'd0);
    do_frame("t6_write", 8'h02, 16'h0044, 32'hA5A50F0F, NONE, NONE, 0, '0, 1, 0, 32'h0, 8'h00);

    repeat (20) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
